vram_pixel_feeder: RTL
======================

# vram_pixel_feeder

Writer side of the dual-bank pixel VRAM used by the VGA output module. It accepts a byte stream (e.g. from the network/DDR receive path), assembles bytes into RGB888 pixels, and issues single-pixel write requests against the VRAM `vram_ready`/`vram_req` handshake. It also counts pixels per frame against the active modeline, so the host side knows when a full field has been delivered.

## Interface
- `FRAME_W`, 24: width of the pixel counters.
- `clk_sys`  in  1  system clock; all logic is on the rising edge.
- `feeder_reset`  in  1  synchronous, active-high reset.
- `H`  in  16  visible width in pixels; sampled on `frame_start`.
- `V`  in  16  visible height in lines; sampled on `frame_start`.
- `interlaced`  in  1  if 1, a frame is `(H*V)>>1` pixels; sampled on `frame_start`.
- `fmt_565`  in  1  input byte format select (see Configuration); sampled on `frame_start`.
- `frame_start`  in  1  one-cycle pulse; starts a new frame.
- `in_valid`  in  1  byte stream valid.
- `in_data`  in  8  byte stream data.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `vram_ready`  in  1  VRAM can take a pixel this cycle.
- `vram_req`  out  1  one-cycle write request.
- `r_vram_out`, `g_vram_out`, `b_vram_out`  out  8 each  pixel data presented to VRAM.
- `pixels_written`  out  FRAME_W  pixels issued in the current frame.
- `frame_done`  out  1  one-cycle pulse when the last pixel of a frame is issued.
- `overrun`  out  1  sticky flag: pixel issued after frame complete; cleared by `frame_start`/reset.

## Operation
- Byte assembler: byte index `bidx` counts 0..2 (RGB888) or 0..1 (RGB565).
  - RGB888 byte order: R, G, B.
  - RGB565 byte order: low byte first, then high byte; the 16-bit word is R[15:11] G[10:5] B[4:0].
  - 565 expansion: R8={r5,r5[4:2]}, G8={g6,g6[5:4]}, B8={b5,b5[4:2]}.
- One-entry pixel holding register `pix_full`. `in_ready = !pix_full && !frame_blk`. The final byte of a pixel sets `pix_full`.
- States:
  - IDLE: after reset; `in_ready=0`. `frame_start` -> FILL.
  - FILL: accept bytes. When `pix_full` -> ISSUE.
  - ISSUE: when `vram_ready && !cool`:
    - assert `vram_req` for one cycle and load the output data registers from the holding register;
    - clear `pix_full`, set `cool` for one cycle, increment `pixels_written`;
    - return to FILL.
  - DONE: entered when `pixels_written` reaches `frame_pixels = (H*V)>>interlaced`. Pulses `frame_done` and sets `frame_blk`.
    - While `frame_blk` is set, `in_ready=0` and bytes are held upstream.
    - `frame_start` -> FILL.
- `frame_start` in any state:
  - zeroes `pixels_written` and `bidx`;
  - drops any partial or held pixel;
  - clears `frame_blk` and `overrun`;
  - latches the config inputs;
  - goes to FILL.
- Arithmetic: `frame_pixels` is computed at FRAME_W bits from the latched H, V. The 32-bit product is truncated. `H=0` or `V=0` means DONE is never reached and the block streams forever.
- `overrun` is set if a `vram_req` fires while `pixels_written >= frame_pixels`. This is unreachable by design; it exists as a checker hook.

## Timing
- Reset values:
  - `vram_req=0`, RGB outputs 0, `in_ready=0`, `pixels_written=0`, `frame_done=0`, `overrun=0`;
  - state IDLE, `bidx=0`, `pix_full=0`, `cool=0`.
- Write handshake:
  - The VRAM registers the request and writes data one cycle later. RGB outputs therefore change only in a `vram_req` cycle and hold until the next `vram_req`.
  - `vram_req` is never asserted on consecutive cycles (`cool`), giving a maximum rate of 1 pixel per 2 clocks.
- Latency:
  - The final byte is accepted at edge t; `vram_req` is asserted at t+1 if `vram_ready` is high.
  - `in_ready` reasserts at the edge after `vram_req`.
- `vram_ready` low: the pixel is held with no byte loss; `in_ready` stays 0.
- `frame_done` coincides with the cycle after the final `vram_req`.
- Simultaneous `frame_start` and a `vram_req` condition: `frame_start` wins, and no request is issued.

## Configuration
- `FEEDER_RGB565_EN`:
  - Defined: `fmt_565` is honoured and the 2-byte assembly and expansion path is built.
  - Undefined: `fmt_565` is ignored (treated as 0), only RGB888 assembly exists, and `bidx` is a fixed 0..2 counter.

## Structure
- Shared package `vram_pkg`:
  - the format enum (FMT_888, FMT_565);
  - the state enum (IDLE, FILL, ISSUE, DONE);
  - the `rgb565_to_888` function;
  - `FRAME_W`.
- One sub-module, `pixel_assembler`: the byte-to-pixel unpacker with the holding register (`in_valid`/`in_ready` in, `pix_valid`/`pix_take` out). The parent module owns the FSM, the handshake and the counters.

## Test plan
- RGB888 stream: bytes 0x11,0x22,0x33 with `vram_ready=1` -> one `vram_req` one cycle after the third byte, RGB=11/22/33, `pixels_written=1`.
- Back-to-back with `in_valid` held high: 6 bytes -> two `vram_req` pulses at least 2 cycles apart, with data stable between them.
- Backpressure: `vram_ready=0` for 10 cycles with a pixel held -> `in_ready=0`, no `vram_req`, no byte lost; the request issues the cycle after `vram_ready` rises.
- Frame end: H=4, V=2, `interlaced=1` -> `frame_done` after the 4th pixel, `in_ready=0` until `frame_start`, `overrun=0`.
- Mid-pixel `frame_start` after 2 bytes -> partial pixel dropped; the next 3 bytes form pixel 1 of the new frame with `pixels_written=1`.
- With `FEEDER_RGB565_EN` defined and `fmt_565=1`: bytes 0x1F,0xF8 (word 0xF81F) -> RGB=FF/00/FF.

Source files
------------

// File: rtl/vram_pkg.sv
// Shared types and helpers for the VRAM pixel write path.
//   FRAME_W        : width of the per-frame pixel counters
//   fmt_t          : input byte format (RGB888 / RGB565)
//   state_t        : feeder control states
//   rgb_t          : packed RGB888 pixel
//   rgb565_to_888  : bit-replicating 565 -> 888 expansion
package vram_pkg;

  localparam int unsigned FRAME_W = 24;
  localparam int unsigned DIM_W   = 16;
  localparam int unsigned BYTE_W  = 8;

  typedef enum logic {
    FMT_888 = 1'b0,
    FMT_565 = 1'b1
  } fmt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] r;
    logic [BYTE_W-1:0] g;
    logic [BYTE_W-1:0] b;
  } rgb_t;

  // Replicate the top bits into the low bits so full-scale stays full-scale.
  function automatic rgb_t rgb565_to_888(input logic [15:0] w);
    rgb_t p;
    p.r = {w[15:11], w[15:13]};
    p.g = {w[10:5],  w[10:9]};
    p.b = {w[4:0],   w[4:2]};
    return p;
  endfunction

endpackage

// File: rtl/pixel_assembler.sv
// Byte-to-pixel unpacker with a one-entry pixel holding register.
// Optional feature macro: FEEDER_RGB565_EN (adds the 2-byte RGB565 path).
// Ports:
//   clk_sys, feeder_reset : clock, synchronous active-high reset
//   flush                 : drop partial and held pixel, restart at byte 0
//   blk                   : block byte acceptance (frame closed / not started)
//   fmt                   : latched input byte format
//   in_valid/in_data      : byte stream in; in_ready out
//   pix_valid, pix        : held pixel
//   pix_done_c            : final byte of a pixel accepted this cycle
//   pix_take              : consumer takes the held pixel this cycle
module pixel_assembler
  import vram_pkg::*;
(
  input  logic              clk_sys,
  input  logic              feeder_reset,
  input  logic              flush,
  input  logic              blk,
  input  fmt_t              fmt,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              pix_valid,
  output logic              pix_done_c,
  output rgb_t              pix,
  input  logic              pix_take
);

  logic [1:0]        bidx;
  logic              pix_full;
  logic [BYTE_W-1:0] byte0;
  logic [BYTE_W-1:0] byte1;
  rgb_t              pix_q;
  logic              accept_c;
  logic              last_c;
  rgb_t              asm_c;

  assign in_ready = !pix_full && !blk;
  assign accept_c = in_valid && in_ready;

`ifdef FEEDER_RGB565_EN
  // 565 words arrive low byte first, so the final byte is the high half.
  assign last_c = (fmt == FMT_565) ? (bidx == 2'd1) : (bidx == 2'd2);
  assign asm_c  = (fmt == FMT_565) ? rgb565_to_888({in_data, byte0})
                                   : rgb_t'({byte0, byte1, in_data});
`else
  logic unused_fmt;
  assign unused_fmt = (fmt == FMT_565);
  assign last_c     = (bidx == 2'd2);
  assign asm_c      = rgb_t'({byte0, byte1, in_data});
`endif

  assign pix_done_c = accept_c && last_c && !flush;
  assign pix_valid  = pix_full;
  assign pix        = pix_q;

  // Byte index, partial bytes and holding register.
  always_ff @(posedge clk_sys) begin
    if (feeder_reset) begin
      bidx     <= 2'd0;
      pix_full <= 1'b0;
      byte0    <= '0;
      byte1    <= '0;
      pix_q    <= '0;
    end else if (flush) begin
      bidx     <= 2'd0;
      pix_full <= 1'b0;
    end else begin
      if (pix_take) begin
        pix_full <= 1'b0;
      end
      if (accept_c) begin
        if (last_c) begin
          pix_q    <= asm_c;
          pix_full <= 1'b1;
          bidx     <= 2'd0;
        end else begin
          if (bidx == 2'd0) begin
            byte0 <= in_data;
          end else begin
            byte1 <= in_data;
          end
          bidx <= bidx + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vram_pixel_feeder.sv
// Writer side of the dual-bank pixel VRAM: assembles a byte stream into
// RGB888 pixels, issues single-pixel writes on the vram_ready/vram_req
// handshake (at most one request every two clocks) and counts pixels
// against the active modeline.
// Optional feature macro: FEEDER_RGB565_EN (honour fmt_565 / RGB565 input).
// Ports:
//   clk_sys, feeder_reset         : clock, synchronous active-high reset
//   H, V, interlaced, fmt_565     : modeline/format, latched on frame_start
//   frame_start                   : one-cycle pulse, starts a new frame
//   in_valid, in_data, in_ready   : byte stream
//   vram_ready, vram_req          : VRAM write handshake
//   r/g/b_vram_out                : pixel data, changes only with vram_req
//   pixels_written                : pixels issued in the current frame
//   frame_done                    : pulse after the last pixel of a frame
//   overrun                       : sticky, pixel issued past frame end
module vram_pixel_feeder #(
  parameter int unsigned FRAME_W = vram_pkg::FRAME_W
) (
  input  logic               clk_sys,
  input  logic               feeder_reset,
  input  logic [15:0]        H,
  input  logic [15:0]        V,
  input  logic               interlaced,
  input  logic               fmt_565,
  input  logic               frame_start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  input  logic               vram_ready,
  output logic               vram_req,
  output logic [7:0]         r_vram_out,
  output logic [7:0]         g_vram_out,
  output logic [7:0]         b_vram_out,
  output logic [FRAME_W-1:0] pixels_written,
  output logic               frame_done,
  output logic               overrun
);
  import vram_pkg::*;

  state_t             state_q;
  state_t             state_d;
  logic               issue_c;
  logic               last_c;
  logic               cool;
  logic               frame_blk;
  logic               done_pend;
  logic [FRAME_W-1:0] frame_pixels;
  fmt_t               fmt_q;
  logic [31:0]        prod_c;
  logic [FRAME_W-1:0] pw_inc_c;
  logic               pix_valid;
  logic               pix_done_c;
  rgb_t               pix;

  assign prod_c   = 32'(H) * 32'(V);
  assign pw_inc_c = pixels_written + FRAME_W'(1);

  pixel_assembler u_asm (
    .clk_sys      (clk_sys),
    .feeder_reset (feeder_reset),
    .flush        (frame_start),
    .blk          (frame_blk),
    .fmt          (fmt_q),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .pix_valid    (pix_valid),
    .pix_done_c   (pix_done_c),
    .pix          (pix),
    .pix_take     (issue_c)
  );

  // State register.
  always_ff @(posedge clk_sys) begin
    if (feeder_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and issue decision; frame_start overrides everything.
  always_comb begin
    state_d = state_q;
    issue_c = 1'b0;
    last_c  = 1'b0;
    unique case (state_q)
      IDLE:  state_d = IDLE;
      FILL:  if (pix_done_c) state_d = ISSUE;
      ISSUE: begin
        if (vram_ready && !cool && pix_valid) begin
          issue_c = 1'b1;
          // A zero-sized frame never completes: the block streams forever.
          last_c  = (frame_pixels != '0) && (pw_inc_c == frame_pixels);
          state_d = last_c ? DONE : FILL;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (frame_start) begin
      state_d = FILL;
      issue_c = 1'b0;
      last_c  = 1'b0;
    end
  end

  // Handshake, output data, counters and frame flags.
  always_ff @(posedge clk_sys) begin
    if (feeder_reset) begin
      vram_req       <= 1'b0;
      r_vram_out     <= '0;
      g_vram_out     <= '0;
      b_vram_out     <= '0;
      pixels_written <= '0;
      frame_done     <= 1'b0;
      overrun        <= 1'b0;
      cool           <= 1'b0;
      done_pend      <= 1'b0;
      frame_blk      <= 1'b1; // closed until the first frame_start
      frame_pixels   <= '0;
      fmt_q          <= FMT_888;
    end else begin
      vram_req   <= issue_c;
      cool       <= issue_c;
      done_pend  <= last_c;
      frame_done <= done_pend;
      if (issue_c) begin
        r_vram_out     <= pix.r;
        g_vram_out     <= pix.g;
        b_vram_out     <= pix.b;
        pixels_written <= pw_inc_c;
      end
      if (last_c) begin
        frame_blk <= 1'b1;
      end
      if (issue_c && (frame_pixels != '0) && (pixels_written >= frame_pixels)) begin
        overrun <= 1'b1;
      end
      if (frame_start) begin
        pixels_written <= '0;
        frame_blk      <= 1'b0;
        overrun        <= 1'b0;
        frame_pixels   <= FRAME_W'(prod_c) >> interlaced;
`ifdef FEEDER_RGB565_EN
        fmt_q          <= fmt_565 ? FMT_565 : FMT_888;
`else
        fmt_q          <= FMT_888;
`endif
      end
    end
  end

`ifndef FEEDER_RGB565_EN
  logic unused_fmt_565;
  assign unused_fmt_565 = fmt_565;
`endif

endmodule
